// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;

  // Rounded clocks-per-oversample-tick, never below one.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_xcvr.sv
// Single-clock UART transceiver with parity, 1/2 stop bits and 16x-oversampled RX.
// Optional macro UART_BREAK_DETECT_EN adds the break_det output.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] TxData,
  input  logic                  transmit,
  output logic                  busy,
  output logic                  tx,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  RxValid,
  output logic                  parity_err,
  output logic                  frame_err
`ifdef UART_BREAK_DETECT_EN
  ,
  output logic                  break_det
`endif
);

  localparam int         DIV       = calc_div(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_DBIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_SBIT = 4'(STOP_BITS - 1);
  localparam bit         PAR_EN    = (PARITY_MODE != int'(PAR_NONE));
  localparam bit         PAR_ODD_L = (PARITY_MODE == int'(PAR_ODD));

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ PAR_ODD_L;
  endfunction

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e             tx_state, tx_next;
  logic [3:0]            tx_tcnt, tx_bcnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par, tx_armed, tx_bit_end, tx_d;

  // START waits for a tick boundary (unarmed) before the start bit begins.
  assign tx_bit_end = tick && (tx_tcnt == LAST_TICK) &&
                      (tx_state != TX_START || tx_armed);
  assign busy = (tx_state != TX_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_d    = 1'b1;
    case (tx_state)
      TX_IDLE:   if (transmit) tx_next = TX_START;
      TX_START: begin
        tx_d = ~tx_armed;
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_d = tx_shift[0];
        if (tx_bit_end && tx_bcnt == LAST_DBIT)
          tx_next = PAR_EN ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_d = tx_par;
        if (tx_bit_end) tx_next = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && tx_bcnt == LAST_SBIT) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_armed <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_d;
      if (tx_state == TX_IDLE) begin
        tx_tcnt  <= '0;
        tx_bcnt  <= '0;
        tx_armed <= 1'b0;
      end else if (tick) begin
        if (tx_state == TX_START && !tx_armed) begin
          tx_armed <= 1'b1;
        end else begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_bit_end) tx_bcnt <= (tx_next != tx_state) ? 4'd0 : tx_bcnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == TX_IDLE && transmit) begin
      tx_shift <= TxData;
      tx_par   <= parity_bit(TxData);
    end else if (tx_state == TX_DATA && tx_bit_end) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // ---------------- receiver: synchroniser p0/p1, edge reference p2 ----------------
  logic rx_sync_p0, rx_sync_p1, rx_sync_p2;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_sync_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_sync_p2 <= rx_sync_p1;
    end
  end

  assign rx_fall = rx_sync_p2 & ~rx_sync_p1;

  rx_state_e             rx_state, rx_next;
  logic [3:0]            rx_tcnt, rx_bcnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_sample, rx_done, rx_par_bad, rx_frm_bad;

  // Start bit is checked at tick 8; every later bit 16 ticks after that.
  assign rx_sample = tick && (rx_tcnt == ((rx_state == RX_START) ? MID_TICK : LAST_TICK));
  assign rx_done   = (rx_state == RX_STOP) && rx_sample && (rx_bcnt == LAST_SBIT);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rx_sync_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_sample && rx_bcnt == LAST_DBIT)
                   rx_next = PAR_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_done) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_tcnt <= '0;
      rx_bcnt <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_tcnt <= '0;
      rx_bcnt <= '0;
    end else if (tick) begin
      rx_tcnt <= (rx_state == RX_START && rx_sample) ? 4'd0 : rx_tcnt + 4'd1;
      if (rx_sample) rx_bcnt <= (rx_next != rx_state) ? 4'd0 : rx_bcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_IDLE) begin
      rx_par_bad <= 1'b0;
      rx_frm_bad <= 1'b0;
    end else if (rx_sample) begin
      case (rx_state)
        RX_DATA:   rx_shift   <= {rx_sync_p1, rx_shift[DATA_WIDTH-1:1]};
        RX_PARITY: rx_par_bad <= rx_sync_p1 ^ parity_bit(rx_shift);
        RX_STOP:   if (!rx_sync_p1) rx_frm_bad <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RxValid    <= 1'b0;
      RxData     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      RxValid <= rx_done;
      if (rx_done) begin
        RxData     <= rx_shift;
        parity_err <= rx_par_bad;
        frame_err  <= rx_frm_bad | ~rx_sync_p1;
      end
    end
  end

`ifdef UART_BREAK_DETECT_EN
  logic rx_all_zero;
  logic rx_rise;

  assign rx_rise = ~rx_sync_p2 & rx_sync_p1;

  always_ff @(posedge clk) begin
    if (rx_state == RX_IDLE)
      rx_all_zero <= 1'b1;
    else if (rx_sample)
      rx_all_zero <= rx_all_zero & ~rx_sync_p1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      break_det <= 1'b0;
    else if (rx_done && rx_all_zero && !rx_sync_p1)
      break_det <= 1'b1;
    else if (rx_rise)
      break_det <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: 8E1 loopback, 8O1 bench-driven line, 7N2 loopback.
module tb_uart_xcvr;

  localparam int BIT = 432;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst;

  logic [7:0] txd_e, rxd_e;
  logic       trans_e, busy_e, tx_e, rxv_e, perr_e, ferr_e;
  logic [7:0] txd_o, rxd_o;
  logic       trans_o, busy_o, tx_o, rx_o, rxv_o, perr_o, ferr_o;
  logic [6:0] txd_7, rxd_7;
  logic       trans_7, busy_7, tx_7, rxv_7, perr_7, ferr_7;
`ifdef UART_BREAK_DETECT_EN
  logic brk_e, brk_o, brk_7;
`endif

  uart_xcvr #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e (
    .clk(clk), .reset(rst), .TxData(txd_e), .transmit(trans_e), .busy(busy_e), .tx(tx_e),
    .rx(tx_e), .RxData(rxd_e), .RxValid(rxv_e), .parity_err(perr_e), .frame_err(ferr_e)
`ifdef UART_BREAK_DETECT_EN
    , .break_det(brk_e)
`endif
  );

  uart_xcvr #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1)) u_o (
    .clk(clk), .reset(rst), .TxData(txd_o), .transmit(trans_o), .busy(busy_o), .tx(tx_o),
    .rx(rx_o), .RxData(rxd_o), .RxValid(rxv_o), .parity_err(perr_o), .frame_err(ferr_o)
`ifdef UART_BREAK_DETECT_EN
    , .break_det(brk_o)
`endif
  );

  uart_xcvr #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7 (
    .clk(clk), .reset(rst), .TxData(txd_7), .transmit(trans_7), .busy(busy_7), .tx(tx_7),
    .rx(tx_7), .RxData(rxd_7), .RxValid(rxv_7), .parity_err(perr_7), .frame_err(ferr_7)
`ifdef UART_BREAK_DETECT_EN
    , .break_det(brk_7)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  int n_e = 0, n_o = 0, n_7 = 0;
  logic [7:0] cap_d_e, cap_d_o;
  logic [6:0] cap_d_7;
  logic cap_p_e, cap_f_e, cap_p_o, cap_f_o, cap_p_7, cap_f_7;
  int busy_cyc_e = 0;
  int run_7 = 0, last_run_7 = 0;

  always @(negedge clk) begin
    if (rxv_e) begin n_e++; cap_d_e = rxd_e; cap_p_e = perr_e; cap_f_e = ferr_e; end
    if (rxv_o) begin n_o++; cap_d_o = rxd_o; cap_p_o = perr_o; cap_f_o = ferr_o; end
    if (rxv_7) begin n_7++; cap_d_7 = rxd_7; cap_p_7 = perr_7; cap_f_7 = ferr_7; end
    if (busy_e) busy_cyc_e++;
    if (tx_7 === 1'b1) run_7++;
    else begin
      if (run_7 != 0) last_run_7 = run_7;
      run_7 = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt_e(input int target, input int budget, input string name);
    int i = 0;
    while (n_e < target && i < budget) begin @(negedge clk); i++; end
    check({name, "_timeout"}, 32'(n_e >= target), 32'd1);
    hold(1);
  endtask

  task automatic wait_cnt_7(input int target, input int budget, input string name);
    int i = 0;
    while (n_7 < target && i < budget) begin @(negedge clk); i++; end
    check({name, "_timeout"}, 32'(n_7 >= target), 32'd1);
    hold(1);
  endtask

  task automatic wait_idle_e(input int budget);
    int i = 0;
    while (busy_e && i < budget) begin @(negedge clk); i++; end
    check("busy_drop_timeout", 32'(busy_e), 32'd0);
    hold(1);
  endtask

  // Frame on rx_o: start, 8 data LSB first, parity bit p, one stop bit s, one idle bit.
  task automatic drive_frame_o(input logic [7:0] d, input logic p, input logic s);
    rx_o = 1'b0; hold(BIT);
    for (int i = 0; i < 8; i++) begin rx_o = d[i]; hold(BIT); end
    rx_o = p; hold(BIT);
    rx_o = s; hold(BIT);
    rx_o = 1'b1; hold(BIT);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp;
  } lb_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } drv_vec_t;

  lb_vec_t  lb  [7];
  drv_vec_t drv [4];

  initial begin
    int base;

    lb[0] = '{8'h45, 8'h45};  // E
    lb[1] = '{8'h4E, 8'h4E};  // N
    lb[2] = '{8'h52, 8'h52};  // R
    lb[3] = '{8'h49, 8'h49};  // I
    lb[4] = '{8'h51, 8'h51};  // Q
    lb[5] = '{8'h55, 8'h55};  // U
    lb[6] = '{8'h45, 8'h45};  // E

    // 0x45 has three ones, so its odd-parity bit is 0; 1 is the wrong bit.
    drv[0] = '{8'h45, 1'b1, 1'b1, 1'b1, 1'b0};
    drv[1] = '{8'h45, 1'b0, 1'b1, 1'b0, 1'b0};
    drv[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
    drv[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    txd_e = 8'h00; trans_e = 1'b0;
    txd_o = 8'h00; trans_o = 1'b0; rx_o = 1'b1;
    txd_7 = 7'h00; trans_7 = 1'b0;
    hold(3);

    check("rst_tx_e",   32'(tx_e),   32'd1);
    check("rst_busy_e", 32'(busy_e), 32'd0);
    check("rst_rxd_e",  32'(rxd_e),  32'h0);
    check("rst_rxv_e",  32'(rxv_e),  32'd0);
    check("rst_perr_e", 32'(perr_e), 32'd0);
    check("rst_ferr_e", 32'(ferr_e), 32'd0);
    check("rst_tx_o",   32'(tx_o),   32'd1);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    check("rst_rxd_o",  32'(rxd_o),  32'h0);
    check("rst_tx_7",   32'(tx_7),   32'd1);
    check("rst_rxd_7",  32'(rxd_7),  32'h0);
    rst = 1'b0;
    hold(5);

    // 8E1 loopback: 11 bits * 432 clks plus up to one tick of start alignment.
    for (int k = 0; k < 7; k++) begin
      base = n_e;
      txd_e = lb[k].data; trans_e = 1'b1; busy_cyc_e = 0;
      hold(1);
      trans_e = 1'b0;
      wait_cnt_e(base + 1, 6000, $sformatf("lb%0d", k));
      check($sformatf("lb_data[%0d]", k), 32'(cap_d_e), 32'(lb[k].exp));
      check($sformatf("lb_perr[%0d]", k), 32'(cap_p_e), 32'd0);
      check($sformatf("lb_ferr[%0d]", k), 32'(cap_f_e), 32'd0);
      wait_idle_e(1000);
      check_range($sformatf("lb_busy_len[%0d]", k), busy_cyc_e, 4752, 4780);
      check($sformatf("lb_tx_idle[%0d]", k), 32'(tx_e), 32'd1);
    end

    // 8O1, bench-driven line.
    for (int k = 0; k < 4; k++) begin
      base = n_o;
      drive_frame_o(drv[k].data, drv[k].par, drv[k].stop);
      check($sformatf("drv_cnt[%0d]", k),  32'(n_o),     32'(base + 1));
      check($sformatf("drv_data[%0d]", k), 32'(cap_d_o), 32'(drv[k].data));
      check($sformatf("drv_perr[%0d]", k), 32'(cap_p_o), 32'(drv[k].exp_perr));
      check($sformatf("drv_ferr[%0d]", k), 32'(cap_f_o), 32'(drv[k].exp_ferr));
      check($sformatf("drv_perr_hold[%0d]", k), 32'(perr_o), 32'(drv[k].exp_perr));
      check($sformatf("drv_ferr_hold[%0d]", k), 32'(ferr_o), 32'(drv[k].exp_ferr));
    end

    // Glitch of 4 ticks must be rejected, then a clean frame received.
    base = n_o;
    rx_o = 1'b0; hold(108);
    rx_o = 1'b1; hold(4 * BIT);
    check("glitch_no_rxv", 32'(n_o), 32'(base));
    drive_frame_o(8'h55, 1'b1, 1'b1);
    check("glitch_next_cnt",  32'(n_o),     32'(base + 1));
    check("glitch_next_data", 32'(cap_d_o), 32'h55);
    check("glitch_next_perr", 32'(cap_p_o), 32'd0);
    check("glitch_next_ferr", 32'(cap_f_o), 32'd0);

    // Handshake: second request while busy is dropped.
    base = n_e;
    txd_e = 8'h12; trans_e = 1'b1; hold(1);
    trans_e = 1'b0; hold(50);
    check("hs_busy", 32'(busy_e), 32'd1);
    txd_e = 8'h34; trans_e = 1'b1; hold(1);
    trans_e = 1'b0;
    wait_cnt_e(base + 1, 6000, "hs");
    check("hs_data", 32'(cap_d_e), 32'h12);
    hold(1500);
    check("hs_cnt",  32'(n_e),    32'(base + 1));
    check("hs_idle", 32'(busy_e), 32'd0);

    // Reset in the middle of the data bits.
    base = n_e;
    txd_e = 8'h5A; trans_e = 1'b1; hold(1);
    trans_e = 1'b0; hold(3 * BIT);
    check("prerst_busy", 32'(busy_e), 32'd1);
    rst = 1'b1; hold(1);
    rst = 1'b0;
    check("midrst_tx",   32'(tx_e),   32'd1);
    check("midrst_busy", 32'(busy_e), 32'd0);
    check("midrst_rxd",  32'(rxd_e),  32'h0);
    hold(5000);
    check("midrst_no_rxv", 32'(n_e),  32'(base));
    check("midrst_tx_idle", 32'(tx_e), 32'd1);

    // 7N2 back-to-back via transmit held high.
    base = n_7;
    txd_7 = 7'h7F; trans_7 = 1'b1; hold(2);
    txd_7 = 7'h00;
    wait_cnt_7(base + 1, 6000, "b2b0");
    check("b2b_data0", 32'(cap_d_7), 32'h7F);
    check("b2b_perr0", 32'(cap_p_7), 32'd0);
    check("b2b_ferr0", 32'(cap_f_7), 32'd0);
    hold(1000);
    check("b2b_busy1", 32'(busy_7), 32'd1);
    trans_7 = 1'b0;
    wait_cnt_7(base + 2, 6000, "b2b1");
    check("b2b_data1", 32'(cap_d_7), 32'h00);
    check("b2b_perr1", 32'(cap_p_7), 32'd0);
    check("b2b_ferr1", 32'(cap_f_7), 32'd0);
    // High run before frame 2: seven 1 data bits, two stop bits, then one tick of realignment.
    check_range("b2b_gap", last_run_7, 3888, 3920);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
